// File: rtl/counter_sched_pkg.sv
// counter_sched_pkg
//   Shared definitions for the counter round-robin scheduler.
//   - state_t   : scheduler FSM state (IDLE, RUN, DONE), 2-bit encoding
//   - DEF_NREQ  : default number of requesters
//   - DEF_CW    : default counter/target width
//   - id_width(): width of a requester index for a given requester count
package counter_sched_pkg;

   localparam int DEF_NREQ = 4;
   localparam int DEF_CW   = 4;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   // Index width for n requesters; never narrower than one bit.
   function automatic int id_width(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter
//   Purely combinational round-robin arbiter. The search starts at the
//   requester just after `last` and wraps, so the previous winner has the
//   lowest priority.
//   Ports:
//     req   in  NREQ  request vector
//     last  in  IW    index of the previous winner
//     grant out NREQ  one-hot grant (all zero when no request)
//     idx   out IW    encoded index of the winner (0 when no request)
//     any   out 1     at least one request present
module rr_arbiter
   import counter_sched_pkg::*;
#(
   parameter int NREQ = DEF_NREQ,
   parameter int IW   = id_width(NREQ)
) (
   input  logic [NREQ-1:0] req,
   input  logic [IW-1:0]   last,
   output logic [NREQ-1:0] grant,
   output logic [IW-1:0]   idx,
   output logic            any
);

   int p;

   always_comb begin
      grant = '0;
      idx   = '0;
      any   = 1'b0;
      p     = 0;
      for (int k = 1; k <= NREQ; k++) begin
         p = (int'(last) + k) % NREQ;
         if (!any && req[p]) begin
            grant[p] = 1'b1;
            idx      = IW'(p);
            any      = 1'b1;
         end
      end
   end

endmodule

// File: rtl/counter_rr_scheduler.sv
// counter_rr_scheduler
//   Shares one CW-bit up-counter (delay timer) between NREQ requesters.
//   A requester asks for a delay of N cycles; the round-robin arbiter grants
//   the counter to one requester, the counter runs 0..N, and the finished
//   job is reported on the done handshake.
//
//   Handshakes: a transfer happens on a rising clock edge where valid and
//   ready are both high. req_ready is a one-hot, single-cycle accept strobe
//   computed from req_valid; requesters may withdraw req_valid at any time
//   before acceptance. done_valid stays high (with done_id stable) until
//   done_ready is seen high at an edge.
//
//   Optional feature, macro CNT_SCHED_B2B_EN: when defined, a completion
//   accepted in DONE may immediately start the next job in the same cycle
//   (no IDLE bubble). When undefined, DONE always returns to IDLE.
//
//   Ports:
//     clk         in  1         rising-edge clock
//     reset       in  1         asynchronous active-low reset
//     req_valid   in  NREQ      per-requester job request
//     req_count   in  NREQ*CW   packed targets, requester i at [i*CW +: CW]
//     req_ready   out NREQ      one-hot accept strobe
//     busy        out 1         state is not IDLE
//     cnt         out CW        current counter value
//     done_valid  out 1         completed job pending
//     done_id     out IW        index of completed job
//     done_ready  in  1         consumer accepts the completion
//     dbg_state   out state_t   current FSM state (observation only)
module counter_rr_scheduler
   import counter_sched_pkg::*;
#(
   parameter  int NREQ = DEF_NREQ,
   parameter  int CW   = DEF_CW,
   localparam int IW   = id_width(NREQ)
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [NREQ-1:0]    req_valid,
   input  logic [NREQ*CW-1:0] req_count,
   output logic [NREQ-1:0]    req_ready,
   output logic               busy,
   output logic [CW-1:0]      cnt,
   output logic               done_valid,
   output logic [IW-1:0]      done_id,
   input  logic               done_ready,
   output state_t             dbg_state
);

   state_t          state;
   logic [CW-1:0]   target;
   logic [IW-1:0]   cur_id;
   logic [IW-1:0]   last_grant;

   logic [NREQ-1:0] arb_grant;
   logic [IW-1:0]   arb_idx;
   logic            arb_any;
   logic            grant_en;
   logic            take;
   logic [CW-1:0]   sel_count;

   // last_grant is loaded together with cur_id, so in DONE it already equals
   // cur_id; the back-to-back path needs no separate priority source.
   rr_arbiter #(
      .NREQ (NREQ),
      .IW   (IW)
   ) u_arb (
      .req   (req_valid),
      .last  (last_grant),
      .grant (arb_grant),
      .idx   (arb_idx),
      .any   (arb_any)
   );

   always_comb begin
      grant_en = (state == IDLE);
`ifdef CNT_SCHED_B2B_EN
      grant_en = grant_en || ((state == DONE) && done_ready);
`endif
      take      = grant_en && arb_any;
      req_ready = grant_en ? arb_grant : '0;
      sel_count = req_count[arb_idx*CW +: CW];
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state      <= IDLE;
         cnt        <= '0;
         target     <= '0;
         cur_id     <= '0;
         last_grant <= IW'(NREQ - 1);
      end else if (take) begin
         // A zero-length job goes straight to DONE so completion appears
         // one cycle after the grant, same as target+1 in general.
         target     <= sel_count;
         cur_id     <= arb_idx;
         last_grant <= arb_idx;
         cnt        <= '0;
         state      <= (sel_count == '0) ? DONE : RUN;
      end else begin
         case (state)
            RUN: begin
               // RUN is only entered with target >= 1, so target-1 cannot wrap.
               cnt <= cnt + 1'b1;
               if (cnt == target - 1'b1) state <= DONE;
            end
            DONE: begin
               if (done_ready) state <= IDLE;
            end
            default: ;
         endcase
      end
   end

   assign busy       = (state != IDLE);
   assign done_valid = (state == DONE);
   assign done_id    = cur_id;
   assign dbg_state  = state;

endmodule

// File: tb/tb_counter_rr_scheduler.sv
module tb_counter_rr_scheduler;
  import counter_sched_pkg::*;

  localparam int NREQ = 4;
  localparam int CW   = 4;
  localparam int IW   = 2;

  // ---------------- clock / reset ----------------
  logic               clk   = 1'b0;
  logic               reset = 1'b1;
  logic [NREQ-1:0]    req_valid  = '0;
  logic [NREQ*CW-1:0] req_count  = '0;
  logic               done_ready = 1'b0;
  logic [NREQ-1:0]    req_ready;
  logic               busy;
  logic [CW-1:0]      cnt;
  logic               done_valid;
  logic [IW-1:0]      done_id;
  state_t             dbg_state;

  always #5 clk = ~clk;

  counter_rr_scheduler #(.NREQ(NREQ), .CW(CW)) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_count  (req_count),
    .req_ready  (req_ready),
    .busy       (busy),
    .cnt        (cnt),
    .done_valid (done_valid),
    .done_id    (done_id),
    .done_ready (done_ready),
    .dbg_state  (dbg_state)
  );

  // ---------------- scoreboard state ----------------
  typedef struct packed {
    logic [IW-1:0] id;
    logic [CW-1:0] tgt;
    logic [31:0]   cyc;
  } exp_t;

  exp_t exp_grant_q[$];
  exp_t exp_done_q[$];

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  bit mon_en = 1'b0;

  // reference model: one job in flight at most, described by its grant time
  bit m_inflight = 1'b0;
  int m_gcyc     = 0;
  int m_tgt      = 0;
  int m_done_cyc = 0;
  int m_last     = NREQ - 1;
  int m_idle_cnt = 0;
  bit exp_busy   = 1'b0;
  int exp_cnt    = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s cycle %0d: got %0d expected %0d", name, cyc, act, exp);
    end
  endtask

  function automatic logic [NREQ*CW-1:0] cnts(input int a, input int b, input int c, input int d);
    logic [NREQ*CW-1:0] r;
    r = '0;
    r[0*CW +: CW] = CW'(a);
    r[1*CW +: CW] = CW'(b);
    r[2*CW +: CW] = CW'(c);
    r[3*CW +: CW] = CW'(d);
    return r;
  endfunction

  // Timeline model: a job granted in cycle G with target T first shows
  // done in G+1+T; after the completion is taken in cycle D the next grant
  // may happen in D+1 (or D itself with back-to-back scheduling).
  task automatic model_step(input logic [NREQ-1:0] v, input logic [NREQ*CW-1:0] c, input logic dr);
    bit was_idle, acc, arb;
    int w, t, el;
    exp_busy = m_inflight;
    el = cyc - m_gcyc - 1;
    exp_cnt = m_inflight ? ((el < m_tgt) ? el : m_tgt) : m_idle_cnt;
    was_idle = !m_inflight;
    acc = 1'b0;
    if (m_inflight && cyc >= m_done_cyc && dr) begin
      acc = 1'b1;
      m_inflight = 1'b0;
      m_idle_cnt = m_tgt;
    end
    arb = was_idle;
`ifdef CNT_SCHED_B2B_EN
    arb = arb || acc;
`endif
    if (arb && v != '0) begin
      w = -1;
      for (int k = 1; k <= NREQ; k++) begin
        int p;
        p = (m_last + k) % NREQ;
        if (w < 0 && v[p]) w = p;
      end
      t = int'(c[w*CW +: CW]);
      exp_grant_q.push_back('{id: IW'(w), tgt: CW'(t), cyc: 32'(cyc)});
      exp_done_q.push_back('{id: IW'(w), tgt: CW'(t), cyc: 32'(cyc + 1 + t)});
      m_inflight = 1'b1;
      m_gcyc     = cyc;
      m_tgt      = t;
      m_done_cyc = cyc + 1 + t;
      m_last     = w;
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic step(input logic [NREQ-1:0] v, input logic [NREQ*CW-1:0] c, input logic dr);
    @(posedge clk);
    cyc++;
    #1;
    req_valid  = v;
    req_count  = c;
    done_ready = dr;
    if (reset) model_step(v, c, dr);
  endtask

  task automatic drain(input int n);
    repeat (n) step('0, '0, 1'b1);
  endtask

  // ---------------- monitor ----------------
  exp_t          ge, de;
  logic [IW-1:0] cur_done_id = '0;
  bit            prev_dv = 1'b0;
  bit            prev_taken = 1'b0;
  bit            new_done;

  always @(negedge clk) begin
    if (!mon_en) begin
      prev_dv    = 1'b0;
      prev_taken = 1'b0;
    end else begin
      chk("busy", int'(busy), int'(exp_busy));
      chk("cnt", int'(cnt), exp_cnt);
      if (req_ready != '0) begin
        if (exp_grant_q.size() == 0) chk("unexpected_grant", int'(req_ready), 0);
        else begin
          ge = exp_grant_q.pop_front();
          chk("grant_onehot", int'(req_ready), 1 << ge.id);
          chk("grant_cycle", cyc, int'(ge.cyc));
        end
      end else if (exp_grant_q.size() != 0 && int'(exp_grant_q[0].cyc) <= cyc) begin
        ge = exp_grant_q.pop_front();
        chk("missing_grant", int'(req_ready), 1 << ge.id);
      end
      new_done = done_valid && (!prev_dv || prev_taken);
      if (new_done) begin
        if (exp_done_q.size() == 0) chk("unexpected_done", int'(done_valid), 0);
        else begin
          de = exp_done_q.pop_front();
          chk("done_id", int'(done_id), int'(de.id));
          chk("done_cycle", cyc, int'(de.cyc));
          chk("done_cnt", int'(cnt), int'(de.tgt));
          cur_done_id = de.id;
        end
      end else if (done_valid) begin
        chk("done_id_hold", int'(done_id), int'(cur_done_id));
      end else if (exp_done_q.size() != 0 && int'(exp_done_q[0].cyc) <= cyc) begin
        de = exp_done_q.pop_front();
        chk("missing_done", int'(done_valid), 1);
      end
      prev_dv    = done_valid;
      prev_taken = done_valid && done_ready;
    end
  end

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_busy"}, int'(busy), 0);
    chk({tag, "_cnt"}, int'(cnt), 0);
    chk({tag, "_done_valid"}, int'(done_valid), 0);
    chk({tag, "_done_id"}, int'(done_id), 0);
    chk({tag, "_req_ready"}, int'(req_ready), 0);
    chk({tag, "_state"}, int'(dbg_state), int'(IDLE));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [NREQ-1:0]    rv;
    logic [NREQ*CW-1:0] rc;
    #1 reset = 1'b0;
    #2 chk_reset_outputs("reset");
    @(negedge clk);
    #1 reset = 1'b1;
    mon_en = 1'b1;

    // single job, target 5, completion taken on its first cycle
    step(4'b0001, cnts(5, 0, 0, 0), 1'b0);
    repeat (5) step('0, '0, 1'b0);
    step('0, '0, 1'b1);
    step('0, '0, 1'b0);
    drain(3);

    // all four requesting, count 2, done_ready tied high
    repeat (20) step(4'b1111, cnts(2, 2, 2, 2), 1'b1);
    drain(6);

    // zero-length job on requester 2
    step(4'b0100, cnts(3, 3, 0, 3), 1'b0);
    step('0, '0, 1'b0);
    step('0, '0, 1'b1);
    drain(3);

    // max target held in DONE with done_ready low, other requests noisy
    step(4'b1000, cnts(0, 0, 0, 15), 1'b0);
    repeat (26) step(4'($urandom_range(0, 15)), cnts(1, 2, 3, 4), 1'b0);
    step('0, '0, 1'b1);
    drain(20);

    // reset in the middle of a RUN at cnt=7
    step(4'b0001, cnts(12, 0, 0, 0), 1'b0);
    repeat (8) step('0, '0, 1'b0);
    chk("cnt_before_reset", int'(cnt), 7);
    #2;
    mon_en = 1'b0;
    reset  = 1'b0;
    #1 chk_reset_outputs("midrun_reset");
    exp_grant_q.delete();
    exp_done_q.delete();
    m_inflight = 1'b0;
    m_last     = NREQ - 1;
    m_idle_cnt = 0;
    exp_busy   = 1'b0;
    exp_cnt    = 0;
    repeat (2) step('0, '0, 1'b0);
    @(negedge clk);
    #1 reset = 1'b1;
    mon_en = 1'b1;
    step(4'b1011, cnts(1, 1, 1, 1), 1'b0);
    step('0, '0, 1'b0);
    drain(6);

    // request withdrawn during RUN, done_ready pulsed in RUN and in IDLE
    step(4'b0010, cnts(0, 6, 0, 0), 1'b0);
    step(4'b0010, cnts(0, 9, 0, 0), 1'b0);
    step('0, cnts(5, 5, 5, 5), 1'b1);
    repeat (4) step('0, '0, 1'b0);
    step('0, '0, 1'b1);
    step('0, '0, 1'b1);
    step('0, '0, 1'b1);
    drain(4);

    // randomized traffic
    repeat (400) begin
      rv = ($urandom_range(0, 9) < 3) ? '0 : NREQ'($urandom_range(1, 15));
      for (int i = 0; i < NREQ; i++)
        rc[i*CW +: CW] = ($urandom_range(0, 9) == 0) ? CW'(15) : CW'($urandom_range(0, 3));
      step(rv, rc, 1'($urandom_range(0, 3) != 0));
    end
    drain(40);

    chk("grant_q_empty", exp_grant_q.size(), 0);
    chk("done_q_empty", exp_done_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
